// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the sequential load unit.
//   * funct3 encodings for the supported load types
//   * FSM state enum used by load_seq_unit
//   * size_bytes(): access size in bytes for a funct3, 0 if the code is not a load
//   * is_signed():  1 for loads whose result is sign-extended
// Configuration macro (used by load_seq_unit): LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_t;

    // LD/LWU are reported with their natural size here; whether they are
    // legal for the configured word width is decided by the caller.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] size;
        case (funct3)
            F3_LB, F3_LBU: size = 4'd1;
            F3_LH, F3_LHU: size = 4'd2;
            F3_LW, F3_LWU: size = 4'd4;
            F3_LD:         size = 4'd8;
            default:       size = 4'd0;
        endcase
        return size;
    endfunction

    function automatic logic is_signed(input logic [2:0] funct3);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW);
    endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract -- combinational extraction / alignment / extension of load data.
// Ports:
//   i_word   [2*DATA_W]  {hi, lo} memory words (hi = 0 for single-beat loads)
//   i_off    [OFF_W]     byte offset of the access inside the lo word
//   i_funct3 [3]         load type, selects size and signedness
//   o_data   [DATA_W]    extracted and extended result
module load_extract
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [2*DATA_W-1:0] i_word,
    input  logic [OFF_W-1:0]    i_off,
    input  logic [2:0]          i_funct3,
    output logic [DATA_W-1:0]   o_data
);

    localparam int BYTES = DATA_W / 8;

    logic [DATA_W-1:0] w_shifted;
    logic [3:0]        w_size;
    logic              w_fill;

    // Only the low DATA_W bits survive the shift; the largest access is one word.
    assign w_shifted = DATA_W'(i_word >> {i_off, 3'b000});
    assign w_size    = size_bytes(i_funct3);

    always_comb begin
        w_fill = 1'b0;
        case (w_size)
            4'd1:    w_fill = w_shifted[7];
            4'd2:    w_fill = w_shifted[15];
            4'd4:    w_fill = w_shifted[31];
            default: w_fill = w_shifted[DATA_W-1];
        endcase
        if (!is_signed(i_funct3)) begin
            w_fill = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_byte
            assign o_data[gi*8 +: 8] = (4'(gi) < w_size) ? w_shifted[gi*8 +: 8]
                                                        : {8{w_fill}};
        end
    endgenerate

endmodule

// File: rtl/load_seq_unit.sv
// load_seq_unit -- sequential load unit between the MEM stage and data memory.
// Takes one load at a time, issues one or two word-aligned reads on a
// single-outstanding memory port, and returns the extended result.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_req_valid/o_req_ready           request handshake
//   i_req_addr [ADDR_W], i_req_funct3 byte address and load type
//   o_mem_req/i_mem_gnt, o_mem_addr   memory read request (word aligned)
//   i_mem_rvalid, i_mem_rdata         memory read data return
//   o_rsp_valid/i_rsp_ready           response handshake
//   o_rsp_data [DATA_W], o_rsp_err    result and reject flag
// Configuration macro: LSU_MISALIGN_TRAP_EN -- when defined, word-crossing
// loads are rejected with o_rsp_err instead of being split into two beats.
module load_seq_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [2:0]        i_req_funct3,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    lsu_state_t        r_state;
    lsu_state_t        w_state_next;
    logic [ADDR_W-1:0] r_base;
    logic [OFF_W-1:0]  r_off;
    logic [2:0]        r_funct3;
    logic              r_err;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_hi;
`ifndef LSU_MISALIGN_TRAP_EN
    logic              r_split;
`endif

    logic              w_req_fire;
    logic [3:0]        w_size;
    logic              w_legal;
    logic [OFF_W-1:0]  w_off;
    logic              w_split;
    logic              w_reject;
    logic [DATA_W-1:0] w_ext;

    assign w_req_fire = i_req_valid && (r_state == ST_IDLE);
    assign w_size     = size_bytes(i_req_funct3);
    // LD and LWU only exist when the word is 64 bits wide.
    assign w_legal    = (w_size != 4'd0) &&
                        ((DATA_W == 64) ||
                         ((i_req_funct3 != F3_LD) && (i_req_funct3 != F3_LWU)));
    assign w_off      = i_req_addr[OFF_W-1:0];
    assign w_split    = (int'(w_off) + int'(w_size)) > BYTES;
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_reject   = !w_legal || w_split;
`else
    assign w_reject   = !w_legal;
`endif

    // State register and captured request / data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_base   <= '0;
            r_off    <= '0;
            r_funct3 <= '0;
            r_err    <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
`ifndef LSU_MISALIGN_TRAP_EN
            r_split  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_req_fire) begin
                r_base   <= {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                r_off    <= w_off;
                r_funct3 <= i_req_funct3;
                r_err    <= w_reject;
                r_lo     <= '0;
                r_hi     <= '0;   // single-beat loads see zeros above the lo word
`ifndef LSU_MISALIGN_TRAP_EN
                r_split  <= w_split;
`endif
            end
            if ((r_state == ST_WAIT0) && i_mem_rvalid) begin
                r_lo <= i_mem_rdata;
            end
`ifndef LSU_MISALIGN_TRAP_EN
            if ((r_state == ST_WAIT1) && i_mem_rvalid) begin
                r_hi <= i_mem_rdata;
            end
`endif
        end
    end

    // Next state and outputs.
    always_comb begin
        w_state_next = r_state;
        o_req_ready  = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_addr   = '0;
        o_rsp_valid  = 1'b0;
        o_rsp_data   = '0;
        o_rsp_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (w_req_fire) begin
                    w_state_next = w_reject ? ST_RESP : ST_REQ0;
                end
            end
            ST_REQ0: begin
                o_mem_req  = 1'b1;
                o_mem_addr = r_base;
                if (i_mem_gnt) begin
                    w_state_next = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (i_mem_rvalid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    w_state_next = ST_RESP;
`else
                    w_state_next = r_split ? ST_REQ1 : ST_RESP;
`endif
                end
            end
`ifndef LSU_MISALIGN_TRAP_EN
            ST_REQ1: begin
                o_mem_req  = 1'b1;
                // Next word; wraps to 0 at the top of the address space.
                o_mem_addr = r_base + ADDR_W'(BYTES);
                if (i_mem_gnt) begin
                    w_state_next = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (i_mem_rvalid) begin
                    w_state_next = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = r_err;
                o_rsp_data  = r_err ? '0 : w_ext;
                if (i_rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    load_extract #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_extract (
        .i_word   ({r_hi, r_lo}),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

endmodule

// File: tb/tb_load_seq_unit.sv
// tb_load_seq_unit -- directed self-checking bench for load_seq_unit (DATA_W=32).
// A small zero-wait memory model grants requests immediately (unless stalled)
// and returns data one cycle after the grant. Expectations honour
// LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_load_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_f3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    logic        gnt_en;
    logic        model_rv;
    logic        stray_rv;
    logic [31:0] log_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_seq_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_addr   (req_addr),
        .i_req_funct3 (req_f3),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_err    (rsp_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h8899AABB;
            32'h0000_0104: return 32'h11223344;
            32'hFFFF_FFFC: return 32'hDEADBEEF;
            32'h0000_0000: return 32'h01234567;
            default:       return 32'h0;
        endcase
    endfunction

    assign mem_gnt    = mem_req & gnt_en;
    assign mem_rvalid = model_rv | stray_rv;

    always @(posedge clk) begin
        model_rv  <= mem_req && mem_gnt && !rst;
        mem_rdata <= mem_word(mem_addr);
        if (mem_req && mem_gnt) log_q.push_back(mem_addr);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One load transaction. exp_lat=0 skips the latency check (stalled runs).
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] exp_data, input logic exp_err,
                           input int exp_nreq, input logic [31:0] exp_a0,
                           input logic [31:0] exp_a1, input int exp_lat,
                           input int gnt_stall, input int rsp_stall);
        int cyc;
        log_q.delete();
        check_val({tag, ".ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_f3    = f3;
        gnt_en    = (gnt_stall == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < gnt_stall; k++) begin
            check_val({tag, ".stall_req"},  64'(mem_req),   64'd1);
            check_val({tag, ".stall_addr"}, 64'(mem_addr),  64'(exp_a0));
            check_val({tag, ".stall_rdy"},  64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        gnt_en = 1'b1;
        cyc = gnt_stall;
        while (!rsp_valid && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
        if (exp_lat > 0) check_val({tag, ".latency"}, 64'(cyc + 1), 64'(exp_lat));
        check_val({tag, ".data"}, 64'(rsp_data), 64'(exp_data));
        check_val({tag, ".err"},  64'(rsp_err),  64'(exp_err));
        check_val({tag, ".nreq"}, 64'(log_q.size()), 64'(exp_nreq));
        if (exp_nreq >= 1 && log_q.size() >= 1) check_val({tag, ".addr0"}, 64'(log_q[0]), 64'(exp_a0));
        if (exp_nreq >= 2 && log_q.size() >= 2) check_val({tag, ".addr1"}, 64'(log_q[1]), 64'(exp_a1));
        for (int k = 0; k < rsp_stall; k++) begin
            @(posedge clk); #1;
            check_val({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
            check_val({tag, ".hold_data"},  64'(rsp_data),  64'(exp_data));
            check_val({tag, ".hold_err"},   64'(rsp_err),   64'(exp_err));
            check_val({tag, ".hold_rdy"},   64'(req_ready), 64'd0);
        end
        $display("load %s addr=%h f3=%b data=%h err=%b nreq=%0d lat=%0d",
                 tag, addr, f3, rsp_data, rsp_err, log_q.size(), cyc + 1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check_val({tag, ".done_valid"}, 64'(rsp_valid), 64'd0);
        check_val({tag, ".done_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_f3    = '0;
        rsp_ready = 1'b0;
        gnt_en    = 1'b1;
        stray_rv  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst.ready",    64'(req_ready), 64'd1);
        check_val("rst.mem_req",  64'(mem_req),   64'd0);
        check_val("rst.mem_addr", 64'(mem_addr),  64'd0);
        check_val("rst.rsp_vld",  64'(rsp_valid), 64'd0);
        check_val("rst.rsp_data", 64'(rsp_data),  64'd0);
        check_val("rst.rsp_err",  64'(rsp_err),   64'd0);

        // tag, addr, f3, data, err, nreq, a0, a1, lat, gnt_stall, rsp_stall
        do_load("lb103",  32'h103, 3'b000, 32'hFFFFFF88, 1'b0, 1, 32'h100, 32'h0, 3, 0, 0);
        do_load("lh101",  32'h101, 3'b001, 32'hFFFF99AA, 1'b0, 1, 32'h100, 32'h0, 3, 0, 0);
        do_load("lbu102", 32'h102, 3'b100, 32'h00000099, 1'b0, 1, 32'h100, 32'h0, 3, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_load("lhu103", 32'h103, 3'b101, 32'h0, 1'b1, 0, 32'h0, 32'h0, 1, 0, 0);
        do_load("lw102",  32'h102, 3'b010, 32'h0, 1'b1, 0, 32'h0, 32'h0, 1, 0, 0);
        do_load("lwwrap", 32'hFFFFFFFE, 3'b010, 32'h0, 1'b1, 0, 32'h0, 32'h0, 1, 0, 0);
        do_load("lw101",  32'h101, 3'b010, 32'h0, 1'b1, 0, 32'h0, 32'h0, 1, 0, 0);
`else
        do_load("lhu103", 32'h103, 3'b101, 32'h00004488, 1'b0, 2, 32'h100, 32'h104, 5, 0, 0);
        do_load("lw102",  32'h102, 3'b010, 32'h33448899, 1'b0, 2, 32'h100, 32'h104, 5, 0, 0);
        do_load("lwwrap", 32'hFFFFFFFE, 3'b010, 32'h4567DEAD, 1'b0, 2, 32'hFFFFFFFC, 32'h0, 5, 0, 0);
        do_load("lw101",  32'h101, 3'b010, 32'h448899AA, 1'b0, 2, 32'h100, 32'h104, 5, 0, 0);
`endif
        do_load("stall",  32'h104, 3'b010, 32'h11223344, 1'b0, 1, 32'h104, 32'h0, 0, 3, 4);
        do_load("ill111", 32'h100, 3'b111, 32'h0, 1'b1, 0, 32'h0, 32'h0, 1, 0, 0);
        do_load("ld32",   32'h100, 3'b011, 32'h0, 1'b1, 0, 32'h0, 32'h0, 1, 0, 0);

        // Reset while waiting for read data, then a stray rvalid.
        req_valid = 1'b1;
        req_addr  = 32'h100;
        req_f3    = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_val("mid.in_wait", 64'(mem_req), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("mid.ready",    64'(req_ready), 64'd1);
        check_val("mid.mem_req",  64'(mem_req),   64'd0);
        check_val("mid.mem_addr", 64'(mem_addr),  64'd0);
        check_val("mid.rsp_vld",  64'(rsp_valid), 64'd0);
        check_val("mid.rsp_data", 64'(rsp_data),  64'd0);
        check_val("mid.rsp_err",  64'(rsp_err),   64'd0);
        stray_rv = 1'b1;
        @(posedge clk); #1;
        stray_rv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("stray.rsp_vld", 64'(rsp_valid), 64'd0);
        check_val("stray.ready",   64'(req_ready), 64'd1);
        $display("load reset_mid addr=00000100 abandoned");
        do_load("lb100",  32'h100, 3'b000, 32'hFFFFFFBB, 1'b0, 1, 32'h100, 32'h0, 3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_seq_unit.md
Name: load_seq_unit

Overview:
- Sequential, parametrised successor to the combinational load-alignment logic.
- Accepts one load request at a time (address + funct3) and issues one or two word-aligned reads on a single-outstanding memory port.
- A load that crosses a word boundary takes two beats. The unit then extracts, aligns and sign/zero-extends the data and returns it through a valid/ready response port.
- Sits between the core's MEM stage and the data memory.

Parameters:
- DATA_W, 32: memory word and result width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  load request valid.
- o_req_ready  out  1  unit idle, can accept a request.
- i_req_addr  in  ADDR_W  byte address.
- i_req_funct3  in  3  load type.
- o_mem_req  out  1  memory read request.
- o_mem_addr  out  ADDR_W  word-aligned read address; low log2(DATA_W/8) bits are 0.
- i_mem_gnt  in  1  memory accepted o_mem_req this cycle.
- i_mem_rvalid  in  1  read data valid.
- i_mem_rdata  in  DATA_W  read data.
- o_rsp_valid  out  1  result valid.
- i_rsp_ready  in  1  consumer accepts result.
- o_rsp_data  out  DATA_W  extended load result.
- o_rsp_err  out  1  request rejected (illegal funct3 or trapped misalignment).

Behaviour:
- Reset values: state IDLE; o_mem_req=0, o_mem_addr=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0. o_req_ready=1 one cycle after reset.
- Legal funct3 codes:
  - Always: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - DATA_W=64 only: LD 011, LWU 110.
  - Anything else is illegal.
- Size decoding and split rule:
  - size = 1, 2, 4 or 8 bytes; off = addr mod (DATA_W/8).
  - split = (off + size > DATA_W/8).
- FSM states:
  - IDLE: o_req_ready=1. On valid&ready, latch addr, funct3, off, split.
    - Illegal funct3 goes to RESP with err=1, data=0.
    - Otherwise goes to REQ0.
  - REQ0: o_mem_req=1, o_mem_addr=aligned(addr). Hold both stable until i_mem_gnt, then go to WAIT0.
  - WAIT0: on i_mem_rvalid, capture lo word. Go to REQ1 if split, else RESP.
  - REQ1: o_mem_addr = aligned(addr) + DATA_W/8, modulo 2^ADDR_W (wraps to 0). On gnt go to WAIT1.
  - WAIT1: on i_mem_rvalid, capture hi word, then go to RESP.
  - RESP: o_rsp_valid=1; data and err held stable. On i_rsp_ready go to IDLE. No new request is accepted in the same cycle.
- Data assembly:
  - Form {hi,lo} (hi=0 if not split) and shift right by off*8.
  - Take the low size bytes.
  - Signed loads (LB, LH, LW when DATA_W=64) replicate the top extracted bit. Unsigned loads (and LW/LD at full width) zero-fill.
- Memory timing rules:
  - i_mem_rvalid is never in the same cycle as its gnt.
  - rvalid in any state other than WAIT0/WAIT1 is ignored.
  - gnt outside REQ0/REQ1 is ignored.
- Minimum latency (accept edge = cycle 0, zero-wait memory):
  - Aligned: o_rsp_valid in cycle 3.
  - Split: o_rsp_valid in cycle 5.
- Reset mid-operation abandons the transaction and returns to IDLE. A late rvalid arriving after reset is ignored.
- o_rsp_err=0 for all legal accesses.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: any legal request with split=1 issues no memory access and goes IDLE→RESP with err=1, data=0 (response in cycle 1). REQ1/WAIT1 are not synthesised.
- Undefined: split accesses are handled with two beats as above.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (LB..LWU).
  - State enum (IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP).
  - Function size_bytes(funct3), returning 0 for illegal.
  - Function is_signed(funct3).
- Sub-module load_extract: combinational; inputs {hi,lo}, off, funct3; output extended DATA_W result. Instantiated once; unit-testable alone.

Test Plan:
- Memory preload (DATA_W=32): 0x100=0x8899AABB, 0x104=0x11223344.
- LB at 0x103 → one mem req to 0x100; rsp_data=0xFFFFFF88, err=0; rsp_valid in cycle 3 with zero-wait memory.
- LHU at 0x103 → mem reqs 0x100 then 0x104; rsp_data=0x00004488. LH at 0x101 → 0xFFFF99AA, single beat.
- LW at 0x102 → split; rsp_data=0x33448899. LW at 0xFFFFFFFE → reqs 0xFFFFFFFC then 0x00000000 (wrap).
- Backpressure and stall: i_mem_gnt held low 3 cycles in REQ0, then i_rsp_ready held low 4 cycles in RESP. o_mem_addr, rsp_data and err stay stable; o_req_ready stays 0 throughout.
- Illegal and reset cases:
  - funct3=111 → no o_mem_req; rsp err=1, data=0.
  - i_rst asserted in WAIT0 → IDLE next cycle, all outputs at reset values; subsequent stray rvalid causes no response.
- LSU_MISALIGN_TRAP_EN defined: LW at 0x101 → no mem req, err=1, data=0. DATA_W=64 build: LD at 0x104 → split across 0x100/0x108.
